vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator producing horizontal and vertical sync, blanking, and display-enable from a single pixel clock domain. It supersedes the fixed-timing line counter: geometry and sync polarity are parameters, there is a pixel-rate clock enable, and it adds line/frame start strobes. It sits between the clock/enable source and the pixel/character pipeline, which consumes `hq`/`vq` as the current raster position.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HSYNC_POL`, 0, asserted level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0, asserted level of `vsync`
- Derived: H_TOTAL = sum of H terms, V_TOTAL = sum of V terms; HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL). Every term ≥ 1.

Ports:
- `clk` in 1, pixel-domain clock
- `rst_n` in 1, synchronous, active-low reset
- `pix_en` in 1, pixel advance enable; the raster advances only on cycles where it is 1
- `hq` out HW, horizontal position 0..H_TOTAL-1
- `vq` out VW, vertical position 0..V_TOTAL-1
- `hsync` out 1, horizontal sync at HSYNC_POL when asserted
- `vsync` out 1, vertical sync at VSYNC_POL when asserted
- `hblank_n` out 1, 1 while hq < H_ACTIVE
- `vblank_n` out 1, 1 while vq < V_ACTIVE
- `de` out 1, hblank_n & vblank_n
- `line_start` out 1, one-cycle strobe on entering hq = 0
- `frame_start` out 1, one-cycle strobe on entering (hq, vq) = (0, 0)

## Operation
- Two counters. On a `pix_en` cycle: hq increments; at H_TOTAL-1 it wraps to 0 and vq increments; vq wraps V_TOTAL-1 → 0 on the same edge as hq's wrap.
- Line order: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Frame order is the same with V terms.
- hsync asserted iff hq is in the sync window. vsync asserted iff vq is in the V sync window. vsync therefore changes only on hq wrap edges.
- Every output is a register. Its value always describes the current `hq`/`vq` on the same cycle, so there is zero skew between position and flags. Flags are decoded from the next counter value.
- `pix_en` = 0: all outputs hold, except `line_start`/`frame_start`, which are forced to 0.
- `line_start` = 1 for exactly the cycle after a `pix_en` edge that moved hq to 0. `frame_start` is likewise set when both counters moved to 0, and coincides with a `line_start`.
- Reset (`rst_n` = 0 at a rising edge, regardless of `pix_en`, at any point in the frame):
  - hq = 0, vq = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - hblank_n = 1, vblank_n = 1, de = 1
  - line_start = 0, frame_start = 0
  - No start strobe is issued for the reset position. The first `frame_start` occurs after a full frame.
- Reset dominates `pix_en`.

## Timing
- Latency: zero cycles from a counter value to its flags (same register stage).
- With `pix_en` tied high:
  - Line period is H_TOTAL clocks; frame period is H_TOTAL × V_TOTAL clocks (800 × 525 = 420000 for the defaults).
  - hsync is asserted for H_SYNC consecutive clocks per line.
  - vsync is asserted for V_SYNC × H_TOTAL consecutive clocks.
- With `pix_en` high one cycle in N, all periods scale by N. Strobes remain one clock wide.
- The first `pix_en` edge after reset release moves hq to 1.

## Test plan
- Defaults, `pix_en` = 1, 1 frame + 10 lines after reset:
  - hsync low exactly for hq 656..751, 96 clocks per line.
  - hblank_n falls at hq = 640.
  - vsync low for vq 490..491, 1600 clocks.
  - `frame_start` period is 420000 clocks.
  - de high for 640 × 480 clocks per frame.
- Defaults, `pix_en` toggling every other cycle:
  - Line period is 1600 clocks.
  - Outputs are stable on `pix_en` = 0 cycles.
  - `line_start` is 1 clock wide, every 1600 clocks.
- Small geometry H = 4/1/2/1, V = 3/1/1/1, HSYNC_POL = VSYNC_POL = 1:
  - H_TOTAL = 8; hsync high at hq 5..6.
  - V_TOTAL = 6; vsync high for vq = 4, 8 clocks.
  - hq and vq widths are 3 bits.
- Wrap check, small geometry:
  - At (hq, vq) = (7, 5), the next `pix_en` gives (0, 0), with `line_start` = `frame_start` = 1 for one clock, then 0.
- Reset mid-frame, defaults:
  - Assert `rst_n` = 0 at (700, 491), with vsync and hsync both asserted.
  - The next edge gives hq = vq = 0, hsync = vsync = 1, de = 1, strobes 0.
  - After release, the first `frame_start` occurs after 420000 `pix_en` edges.
- `rst_n` = 0 while `pix_en` = 0:
  - Reset still takes effect on that edge.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: horizontal/vertical counters with
// registered sync, blanking, display-enable and line/frame start strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [HW-1:0] hq,
    output logic [VW-1:0] vq,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank_n,
    output logic          vblank_n,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hq_q, hq_d;
    logic [VW-1:0] vq_q, vq_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          hblank_n_q, hblank_n_d;
    logic          vblank_n_q, vblank_n_d;
    logic          de_q, de_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          h_wrap;
    logic          v_wrap;

    // Flags are decoded from the next counter values so they land in the same
    // register stage as the position they describe.
    always_comb begin
        hq_d          = hq_q;
        vq_d          = vq_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hblank_n_d    = hblank_n_q;
        vblank_n_d    = vblank_n_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_wrap        = (hq_q == H_LAST);
        v_wrap        = (vq_q == V_LAST);
        if (pix_en) begin
            hq_d = h_wrap ? '0 : hq_q + 1'b1;
            if (h_wrap) begin
                vq_d = v_wrap ? '0 : vq_q + 1'b1;
            end
            hsync_d       = (hq_d >= H_SYNC_BEG && hq_d < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (vq_d >= V_SYNC_BEG && vq_d < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
            hblank_n_d    = (hq_d < H_ACT_END);
            vblank_n_d    = (vq_d < V_ACT_END);
            de_d          = hblank_n_d & vblank_n_d;
            line_start_d  = h_wrap;
            frame_start_d = h_wrap & v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hq_q          <= '0;
            vq_q          <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            hblank_n_q    <= 1'b1;
            vblank_n_q    <= 1'b1;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hq_q          <= hq_d;
            vq_q          <= vq_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_n_q    <= hblank_n_d;
            vblank_n_q    <= vblank_n_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hq          = hq_q;
    assign vq          = vq_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank_n    = hblank_n_q;
    assign vblank_n    = vblank_n_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default and small-geometry instances checked every
// cycle against a linear-pixel-index reference model through expected queues.
module tb_vga_timing_gen;

    localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VA = 480, D_VF = 10, D_VS = 2, D_VB = 33;
    localparam int S_HA = 4, S_HF = 1, S_HS = 2, S_HB = 1;
    localparam int S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int D_TOT = (D_HA + D_HF + D_HS + D_HB) * (D_VA + D_VF + D_VS + D_VB);
    localparam int S_TOT = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);
    localparam int EW = 27;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic d_rst_n = 1'b0, d_en = 1'b0;
    logic s_rst_n = 1'b0, s_en = 1'b0;

    logic [9:0] d_hq, d_vq;
    logic       d_hsync, d_vsync, d_hbn, d_vbn, d_de, d_ls, d_fs;
    logic [2:0] s_hq, s_vq;
    logic       s_hsync, s_vsync, s_hbn, s_vbn, s_de, s_ls, s_fs;

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(d_rst_n), .pix_en(d_en),
        .hq(d_hq), .vq(d_vq), .hsync(d_hsync), .vsync(d_vsync),
        .hblank_n(d_hbn), .vblank_n(d_vbn), .de(d_de),
        .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(s_rst_n), .pix_en(s_en),
        .hq(s_hq), .vq(s_vq), .hsync(s_hsync), .vsync(s_vsync),
        .hblank_n(s_hbn), .vblank_n(s_vbn), .de(s_de),
        .line_start(s_ls), .frame_start(s_fs)
    );

    // ---------------- reference model ----------------
    int total_cnt = 0;
    int bad_cnt   = 0;
    int p_d = 0, p_s = 0;
    logic [EW-1:0] exp_d_q[$];
    logic [EW-1:0] exp_s_q[$];
    bit            meas_d_q[$];
    bit            meas_s_q[$];
    bit            meas_d = 1'b0, meas_s = 1'b0;

    // Position is a linear pixel index within the frame; everything else is
    // derived from it with plain division/modulo and window tests.
    function automatic logic [EW-1:0] model_out(input int ha, hf, hs, hb, va, vf, vs, vb,
                                                input bit hp, vp, input int p, input bit ls, fs);
        int ht, h, v;
        logic [9:0] h10, v10;
        logic hsy, vsy, hbn, vbn;
        ht  = ha + hf + hs + hb;
        h   = p % ht;
        v   = p / ht;
        h10 = h[9:0];
        v10 = v[9:0];
        hsy = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
        vsy = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
        hbn = (h < ha);
        vbn = (v < va);
        return {h10, v10, hsy, vsy, hbn, vbn, hbn & vbn, ls, fs};
    endfunction

    function automatic int step_pos(input int p, input int tot, input bit rst_n, input bit en);
        if (!rst_n) return 0;
        if (en) return (p + 1) % tot;
        return p;
    endfunction

    // ---------------- driver ----------------
    task automatic tick(input bit drst, input bit den, input bit srst, input bit sen);
        bit moved;
        @(negedge clk);
        d_rst_n = drst; d_en = den;
        s_rst_n = srst; s_en = sen;
        p_d   = step_pos(p_d, D_TOT, drst, den);
        moved = drst && den;
        exp_d_q.push_back(model_out(D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, 1'b0, 1'b0,
                                    p_d, moved && (p_d % (D_HA + D_HF + D_HS + D_HB) == 0),
                                    moved && (p_d == 0)));
        meas_d_q.push_back(meas_d);
        p_s   = step_pos(p_s, S_TOT, srst, sen);
        moved = srst && sen;
        exp_s_q.push_back(model_out(S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, 1'b1,
                                    p_s, moved && (p_s % (S_HA + S_HF + S_HS + S_HB) == 0),
                                    moved && (p_s == 0)));
        meas_s_q.push_back(meas_s);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int d_hs_cnt = 0, d_hbn_cnt = 0, d_de_cnt = 0, d_ls_cnt = 0;
    int s_hs_cnt = 0, s_vs_cnt = 0, s_de_cnt = 0, s_ls_cnt = 0, s_fs_cnt = 0;
    int cyc = 0;

    task automatic compare(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s cyc=%0d got hq=%0d vq=%0d hs/vs/hb/vb/de/ls/fs=%b want hq=%0d vq=%0d hs/vs/hb/vb/de/ls/fs=%b",
                     name, cyc, act[26:17], act[16:7], act[6:0], exp[26:17], exp[16:7], exp[6:0]);
        end
    endtask

    always @(posedge clk) begin
        logic [EW-1:0] e;
        bit m;
        #1;
        cyc++;
        if (exp_d_q.size() > 0) begin
            e = exp_d_q.pop_front();
            m = meas_d_q.pop_front();
            compare("dflt", {d_hq, d_vq, d_hsync, d_vsync, d_hbn, d_vbn, d_de, d_ls, d_fs}, e);
            if (m) begin
                d_hs_cnt  += (d_hsync == 1'b0) ? 1 : 0;
                d_hbn_cnt += d_hbn ? 1 : 0;
                d_de_cnt  += d_de ? 1 : 0;
                d_ls_cnt  += d_ls ? 1 : 0;
            end
        end
        if (exp_s_q.size() > 0) begin
            e = exp_s_q.pop_front();
            m = meas_s_q.pop_front();
            compare("small", {7'd0, s_hq, 7'd0, s_vq, s_hsync, s_vsync, s_hbn, s_vbn, s_de, s_ls, s_fs}, e);
            if (m) begin
                s_hs_cnt += s_hsync ? 1 : 0;
                s_vs_cnt += s_vsync ? 1 : 0;
                s_de_cnt += s_de ? 1 : 0;
                s_ls_cnt += s_ls ? 1 : 0;
                s_fs_cnt += s_fs ? 1 : 0;
            end
        end
    end

    task automatic check_count(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) tick(0, 0, 0, 0);

        // One full default line and one full small frame with pix_en high.
        meas_d = 1'b1;
        meas_s = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i == S_TOT) meas_s = 1'b0;
            tick(1, 1, 1, 1);
        end
        meas_d = 1'b0;
        meas_s = 1'b0;
        repeat (2400) tick(1, 1, 1, 1);

        // pix_en every other cycle.
        for (int i = 0; i < 3200; i++) tick(1, i[0], 1, i[0]);

        // Reset with pix_en high, run to hq=700 on line 2 (hsync asserted), then
        // reset with pix_en low.
        tick(0, 1, 0, 1);
        repeat (2 * 800 + 700) tick(1, 1, 1, 1);
        tick(0, 0, 0, 0);
        // Small geometry to (6,4): both syncs asserted, then reset with pix_en low.
        repeat (38) tick(1, 1, 1, 1);
        tick(0, 0, 0, 0);
        repeat (2) tick(1, 1, 1, 1);

        // Random pix_en with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 150) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 60) != 0, $urandom_range(0, 3) != 0);
        end

        repeat (3) @(posedge clk);
        #2;
        check_count("queue_drain_dflt", exp_d_q.size(), 0);
        check_count("queue_drain_small", exp_s_q.size(), 0);
        check_count("dflt_hsync_clocks_per_line", d_hs_cnt, D_HS);
        check_count("dflt_hblank_n_clocks_per_line", d_hbn_cnt, D_HA);
        check_count("dflt_de_clocks_line0", d_de_cnt, D_HA);
        check_count("dflt_line_start_per_line", d_ls_cnt, 1);
        check_count("small_hsync_clocks_per_frame", s_hs_cnt, S_HS * 6);
        check_count("small_vsync_clocks_per_frame", s_vs_cnt, S_VS * 8);
        check_count("small_de_clocks_per_frame", s_de_cnt, S_HA * S_VA);
        check_count("small_line_start_per_frame", s_ls_cnt, 6);
        check_count("small_frame_start_per_frame", s_fs_cnt, 1);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
